// File: rtl/pcie_dll_rx_dllp_sched.sv
// pcie_dll_rx_dllp_sched
//   Receive-side DLLP scheduler for the PCIe Data Link Layer. It takes
//   per-TLP check results from the RX TLP checker and tracks NEXT_RCV_SEQ.
//   It decides when Ack, Nak and FC-update DLLPs are due, and drives them
//   one at a time onto a single valid/ready channel toward the DLLP framer.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   rx_evt_valid_i    : one TLP check result this cycle (pulse, no backpressure)
//   rx_evt_crc_ok_i   : LCRC passed for that TLP
//   rx_evt_seq_i      : sequence number of that TLP
//   fc_credit_i       : current free receive-buffer credits
//   fc_update_req_i   : pulse, credits changed, FC update wanted
//   dllp_valid_o      : DLLP held for the framer
//   dllp_ready_i      : framer accepts the held DLLP
//   dllp_type_o       : 0=Ack, 1=Nak, 2=FC update
//   dllp_seq_o        : AckNak_Seq_Num (0 for FC)
//   dllp_fc_o         : credit value (0 for Ack/Nak)
//   tlp_accept_o      : combinational, current event is an in-order good TLP
//   next_rcv_seq_o    : current NEXT_RCV_SEQ
module pcie_dll_rx_dllp_sched #(
  parameter int ACK_TIMEOUT  = 64,
  parameter int ACK_COALESCE = 4,
  parameter int FC_PERIOD    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_evt_valid_i,
  input  logic        rx_evt_crc_ok_i,
  input  logic [11:0] rx_evt_seq_i,
  input  logic [11:0] fc_credit_i,
  input  logic        fc_update_req_i,
  output logic        dllp_valid_o,
  input  logic        dllp_ready_i,
  output logic [1:0]  dllp_type_o,
  output logic [11:0] dllp_seq_o,
  output logic [11:0] dllp_fc_o,
  output logic        tlp_accept_o,
  output logic [11:0] next_rcv_seq_o
);

  localparam int AT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int CC_W = $clog2(ACK_COALESCE + 1);
  localparam int FT_W = $clog2(FC_PERIOD + 1);

  localparam logic [AT_W-1:0] ACK_TMR_MAX = AT_W'(ACK_TIMEOUT - 1);
  localparam logic [CC_W-1:0] COAL_MAX    = CC_W'(ACK_COALESCE);
  localparam logic [FT_W-1:0] FC_TMR_MAX  = FT_W'(FC_PERIOD - 1);

  localparam logic [1:0] TYPE_ACK = 2'd0;
  localparam logic [1:0] TYPE_NAK = 2'd1;
  localparam logic [1:0] TYPE_FC  = 2'd2;

  typedef enum logic [1:0] {IDLE, SEND_NAK, SEND_ACK, SEND_FC} state_e;

  state_e          state_q, state_d;
  logic [11:0]     next_rcv_seq_q, next_rcv_seq_d;
  logic            ack_pending_q, ack_pending_d;
  logic [11:0]     ack_seq_q, ack_seq_d;
  logic            ack_force_q, ack_force_d;
  logic [AT_W-1:0] ack_timer_q, ack_timer_d;
  logic [CC_W-1:0] coal_cnt_q, coal_cnt_d;
  logic            nak_pending_q, nak_pending_d;
  logic [11:0]     nak_seq_q, nak_seq_d;
  logic            nak_scheduled_q, nak_scheduled_d;
  logic [FT_W-1:0] fc_timer_q, fc_timer_d;
  logic            fc_pending_q, fc_pending_d;
  logic            dllp_valid_q, dllp_valid_d;
  logic [1:0]      dllp_type_q, dllp_type_d;
  logic [11:0]     dllp_seq_q, dllp_seq_d;
  logic [11:0]     dllp_fc_q, dllp_fc_d;

  logic [11:0] last_seq;
  logic [11:0] dup_dist;
  logic        evt_inorder;
  logic        evt_dup;
  logic        evt_bad;
  logic        handshake;
  logic        hs_nak;
  logic        hs_ack;
  logic        hs_fc;
  logic        fc_wrap;
  logic        ack_eligible;

  // Event classification. A duplicate lies in the 2048-entry window that
  // ends at the last accepted sequence number (NEXT_RCV_SEQ-1, mod 4096).
  always_comb begin
    last_seq    = next_rcv_seq_q - 12'd1;
    dup_dist    = last_seq - rx_evt_seq_i;
    evt_inorder = rx_evt_valid_i && rx_evt_crc_ok_i && (rx_evt_seq_i == next_rcv_seq_q);
    evt_dup     = rx_evt_valid_i && rx_evt_crc_ok_i && !evt_inorder && !dup_dist[11];
    evt_bad     = rx_evt_valid_i && !evt_inorder && !evt_dup;
    handshake   = dllp_valid_q && dllp_ready_i;
    hs_nak      = handshake && (state_q == SEND_NAK);
    hs_ack      = handshake && (state_q == SEND_ACK);
    hs_fc       = handshake && (state_q == SEND_FC);
    fc_wrap     = (fc_timer_q == FC_TMR_MAX);
  end

  // Pending-flag bookkeeping. Handshake clears are applied first and new
  // event sets after, so an event in the handshake cycle wins. A sent Nak
  // carries the same acknowledgement point, so it also drops any pending Ack.
  always_comb begin
    next_rcv_seq_d  = next_rcv_seq_q;
    ack_pending_d   = ack_pending_q;
    ack_seq_d       = ack_seq_q;
    ack_force_d     = ack_force_q;
    ack_timer_d     = ack_timer_q;
    coal_cnt_d      = coal_cnt_q;
    nak_pending_d   = nak_pending_q;
    nak_seq_d       = nak_seq_q;
    nak_scheduled_d = nak_scheduled_q;
    fc_pending_d    = fc_pending_q;
    fc_timer_d      = fc_wrap ? '0 : fc_timer_q + FT_W'(1);

    if (ack_pending_q && (ack_timer_q != ACK_TMR_MAX)) begin
      ack_timer_d = ack_timer_q + AT_W'(1);
    end

    if (hs_nak) begin
      nak_pending_d = 1'b0;
    end
    if (hs_nak || hs_ack) begin
      ack_pending_d = 1'b0;
      ack_force_d   = 1'b0;
      ack_timer_d   = '0;
      coal_cnt_d    = '0;
    end
    if (hs_fc) begin
      fc_pending_d = 1'b0;
    end

    if (evt_inorder) begin
      next_rcv_seq_d  = next_rcv_seq_q + 12'd1;
      nak_scheduled_d = 1'b0;
      ack_pending_d   = 1'b1;
      ack_seq_d       = rx_evt_seq_i;
      if (coal_cnt_d != COAL_MAX) begin
        coal_cnt_d = coal_cnt_d + CC_W'(1);
      end
    end
    if (evt_dup) begin
      ack_pending_d = 1'b1;
      ack_seq_d     = last_seq;
      ack_force_d   = 1'b1;
    end
    if (evt_bad && !nak_scheduled_q) begin
      nak_pending_d   = 1'b1;
      nak_seq_d       = last_seq;
      nak_scheduled_d = 1'b1;
    end
    if (fc_wrap || fc_update_req_i) begin
      fc_pending_d = 1'b1;
    end

    // The timeout uses the registered timer; coalescing and duplicate forcing
    // use this cycle's values so the Ack can be selected in the event cycle.
    ack_eligible = ack_pending_d &&
                   (ack_force_d || (coal_cnt_d == COAL_MAX) ||
                    (ack_pending_q && (ack_timer_q == ACK_TMR_MAX)));
  end

  // Transmit FSM. IDLE picks Nak > Ack > FC and loads the output register;
  // a SEND state holds it until the handshake and then always returns to
  // IDLE, leaving one idle cycle between DLLPs.
  always_comb begin
    state_d      = state_q;
    dllp_valid_d = dllp_valid_q;
    dllp_type_d  = dllp_type_q;
    dllp_seq_d   = dllp_seq_q;
    dllp_fc_d    = dllp_fc_q;

    case (state_q)
      IDLE: begin
        if (nak_pending_d) begin
          state_d      = SEND_NAK;
          dllp_valid_d = 1'b1;
          dllp_type_d  = TYPE_NAK;
          dllp_seq_d   = nak_seq_d;
          dllp_fc_d    = 12'd0;
        end else if (ack_eligible) begin
          state_d      = SEND_ACK;
          dllp_valid_d = 1'b1;
          dllp_type_d  = TYPE_ACK;
          dllp_seq_d   = ack_seq_d;
          dllp_fc_d    = 12'd0;
        end else if (fc_pending_d) begin
          state_d      = SEND_FC;
          dllp_valid_d = 1'b1;
          dllp_type_d  = TYPE_FC;
          dllp_seq_d   = 12'd0;
          dllp_fc_d    = fc_credit_i;
        end
      end
      SEND_NAK, SEND_ACK, SEND_FC: begin
        if (handshake) begin
          state_d      = IDLE;
          dllp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        dllp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      next_rcv_seq_q  <= '0;
      ack_pending_q   <= 1'b0;
      ack_seq_q       <= '0;
      ack_force_q     <= 1'b0;
      ack_timer_q     <= '0;
      coal_cnt_q      <= '0;
      nak_pending_q   <= 1'b0;
      nak_seq_q       <= '0;
      nak_scheduled_q <= 1'b0;
      fc_timer_q      <= '0;
      fc_pending_q    <= 1'b0;
      dllp_valid_q    <= 1'b0;
      dllp_type_q     <= '0;
      dllp_seq_q      <= '0;
      dllp_fc_q       <= '0;
    end else begin
      state_q         <= state_d;
      next_rcv_seq_q  <= next_rcv_seq_d;
      ack_pending_q   <= ack_pending_d;
      ack_seq_q       <= ack_seq_d;
      ack_force_q     <= ack_force_d;
      ack_timer_q     <= ack_timer_d;
      coal_cnt_q      <= coal_cnt_d;
      nak_pending_q   <= nak_pending_d;
      nak_seq_q       <= nak_seq_d;
      nak_scheduled_q <= nak_scheduled_d;
      fc_timer_q      <= fc_timer_d;
      fc_pending_q    <= fc_pending_d;
      dllp_valid_q    <= dllp_valid_d;
      dllp_type_q     <= dllp_type_d;
      dllp_seq_q      <= dllp_seq_d;
      dllp_fc_q       <= dllp_fc_d;
    end
  end

  assign dllp_valid_o   = dllp_valid_q;
  assign dllp_type_o    = dllp_type_q;
  assign dllp_seq_o     = dllp_seq_q;
  assign dllp_fc_o      = dllp_fc_q;
  assign tlp_accept_o   = evt_inorder;
  assign next_rcv_seq_o = next_rcv_seq_q;

endmodule

// File: tb/tb_pcie_dll_rx_dllp_sched.sv
// tb_pcie_dll_rx_dllp_sched
//   Testbench for pcie_dll_rx_dllp_sched. A behavioural reference model
//   (integer arithmetic mod 4096, pending flags and ages) runs alongside the
//   DUT; scenario tasks compare DUT outputs against fixed expected values and
//   against the model, and a randomized run compares every cycle.
module tb_pcie_dll_rx_dllp_sched;

  localparam int ACK_TIMEOUT  = 64;
  localparam int ACK_COALESCE = 4;
  localparam int FC_PERIOD    = 256;

  typedef struct {
    int t;
    int s;
    int f;
  } dllp_t;

  logic        clk;
  logic        rst;
  logic        rx_evt_valid_i;
  logic        rx_evt_crc_ok_i;
  logic [11:0] rx_evt_seq_i;
  logic [11:0] fc_credit_i;
  logic        fc_update_req_i;
  logic        dllp_valid_o;
  logic        dllp_ready_i;
  logic [1:0]  dllp_type_o;
  logic [11:0] dllp_seq_o;
  logic [11:0] dllp_fc_o;
  logic        tlp_accept_o;
  logic [11:0] next_rcv_seq_o;

  int n_tests = 0;
  int n_fail  = 0;

  dllp_t dut_q[$];
  dllp_t mdl_q[$];
  logic  got_accept;
  bit    want_accept;

  pcie_dll_rx_dllp_sched #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .ACK_COALESCE(ACK_COALESCE),
    .FC_PERIOD   (FC_PERIOD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_evt_valid_i (rx_evt_valid_i),
    .rx_evt_crc_ok_i(rx_evt_crc_ok_i),
    .rx_evt_seq_i   (rx_evt_seq_i),
    .fc_credit_i    (fc_credit_i),
    .fc_update_req_i(fc_update_req_i),
    .dllp_valid_o   (dllp_valid_o),
    .dllp_ready_i   (dllp_ready_i),
    .dllp_type_o    (dllp_type_o),
    .dllp_seq_o     (dllp_seq_o),
    .dllp_fc_o      (dllp_fc_o),
    .tlp_accept_o   (tlp_accept_o),
    .next_rcv_seq_o (next_rcv_seq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: everything is a plain integer or flag.
  int    m_nrs, m_ack_seq, m_nak_seq, m_coal, m_ack_age, m_fc_age;
  bit    m_ack_pend, m_ack_force, m_nak_pend, m_nak_sched, m_fc_pend, m_valid;
  dllp_t m_out;

  function automatic bool_t_dummy_unused();
    return 0;
  endfunction

  task automatic model_drop_ack();
    m_ack_pend  = 0;
    m_ack_force = 0;
    m_coal      = 0;
    m_ack_age   = 0;
  endtask

  task automatic model_load(input int t, input int s, input int f);
    m_out.t = t;
    m_out.s = s;
    m_out.f = f;
    m_valid = 1;
  endtask

  // One clock edge of the protocol: age timers, retire the held DLLP on a
  // handshake, apply the incoming event, then let an idle channel pick
  // Nak > due Ack > FC.
  task automatic model_step();
    int  last, seq;
    bit  inorder, dup, bad, timer_hit, fc_wrap, was_holding;
    seq         = int'(rx_evt_seq_i);
    last        = (m_nrs + 4095) % 4096;
    inorder     = rx_evt_valid_i && rx_evt_crc_ok_i && (seq == m_nrs);
    dup         = rx_evt_valid_i && rx_evt_crc_ok_i && !inorder &&
                  (((last - seq + 4096) % 4096) < 2048);
    bad         = rx_evt_valid_i && !inorder && !dup;
    was_holding = m_valid;
    timer_hit   = m_ack_pend && (m_ack_age == ACK_TIMEOUT - 1);
    if (m_ack_pend && m_ack_age < ACK_TIMEOUT - 1) m_ack_age++;
    fc_wrap  = (m_fc_age == FC_PERIOD - 1);
    m_fc_age = fc_wrap ? 0 : m_fc_age + 1;

    if (m_valid && dllp_ready_i) begin
      mdl_q.push_back(m_out);
      m_valid = 0;
      if (m_out.t == 1) begin
        m_nak_pend = 0;
        model_drop_ack();
      end else if (m_out.t == 0) begin
        model_drop_ack();
      end else begin
        m_fc_pend = 0;
      end
    end

    if (inorder) begin
      m_nrs       = (m_nrs + 1) % 4096;
      m_nak_sched = 0;
      m_ack_pend  = 1;
      m_ack_seq   = seq;
      m_coal      = (m_coal + 1 > ACK_COALESCE) ? ACK_COALESCE : m_coal + 1;
    end
    if (dup) begin
      m_ack_pend  = 1;
      m_ack_seq   = last;
      m_ack_force = 1;
    end
    if (bad && !m_nak_sched) begin
      m_nak_pend  = 1;
      m_nak_seq   = last;
      m_nak_sched = 1;
    end
    if (fc_wrap || fc_update_req_i) m_fc_pend = 1;

    if (!was_holding) begin
      if (m_nak_pend)
        model_load(1, m_nak_seq, 0);
      else if (m_ack_pend && (m_ack_force || m_coal >= ACK_COALESCE || timer_hit))
        model_load(0, m_ack_seq, 0);
      else if (m_fc_pend)
        model_load(2, 0, int'(fc_credit_i));
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_nrs = 0; m_ack_seq = 0; m_nak_seq = 0; m_coal = 0; m_ack_age = 0; m_fc_age = 0;
      m_ack_pend = 0; m_ack_force = 0; m_nak_pend = 0; m_nak_sched = 0;
      m_fc_pend = 0; m_valid = 0;
      m_out = '{0, 0, 0};
    end else begin
      model_step();
    end
  end

  // Drive one cycle of inputs, note the combinational accept and any DUT
  // handshake, then advance to 1 time unit after the clock edge.
  task automatic cycle(input bit ev, input bit crc, input int seq, input bit req);
    rx_evt_valid_i  = ev;
    rx_evt_crc_ok_i = crc;
    rx_evt_seq_i    = 12'(seq);
    fc_update_req_i = req;
    #1;
    got_accept  = tlp_accept_o;
    want_accept = ev && crc && ((seq % 4096) == m_nrs);
    if (!rst && dllp_valid_o === 1'b1 && dllp_ready_i)
      dut_q.push_back('{int'(dllp_type_o), int'(dllp_seq_o), int'(dllp_fc_o)});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    dut_q.delete();
    mdl_q.delete();
  endtask

  task automatic test_reset();
    dllp_ready_i = 1'b1;
    fc_credit_i  = 12'h000;
    rst = 1'b1;
    idle(2);
    n_tests++;
    if (dllp_valid_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_valid got=%b want=0", dllp_valid_o);
    end
    n_tests++;
    if (dllp_type_o !== 2'd0 || dllp_seq_o !== 12'd0 || dllp_fc_o !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_fields got type=%0d seq=%0d fc=%0d want 0/0/0",
               dllp_type_o, dllp_seq_o, dllp_fc_o);
    end
    n_tests++;
    if (next_rcv_seq_o !== 12'd0) begin
      n_fail++; $display("[TB] FAIL reset_next_seq got=%0d want=0", next_rcv_seq_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_coalesce();
    dllp_ready_i = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, i, 0);
      n_tests++;
      if (got_accept !== 1'b1 || !want_accept) begin
        n_fail++; $display("[TB] FAIL coalesce_accept seq=%0d got=%b want=1", i, got_accept);
      end
      n_tests++;
      if (i < 3 && dllp_valid_o !== 1'b0) begin
        n_fail++; $display("[TB] FAIL coalesce_early_ack after seq=%0d got valid=%b want 0", i, dllp_valid_o);
      end else if (i == 3 && (dllp_valid_o !== 1'b1 || dllp_type_o !== 2'd0 || dllp_seq_o !== 12'd3)) begin
        n_fail++;
        $display("[TB] FAIL coalesce_ack got valid=%b type=%0d seq=%0d want 1/0/3",
                 dllp_valid_o, dllp_type_o, dllp_seq_o);
      end
    end
    n_tests++;
    if (next_rcv_seq_o !== 12'd4) begin
      n_fail++; $display("[TB] FAIL coalesce_next_seq got=%0d want=4", next_rcv_seq_o);
    end
    idle(3);
    n_tests++;
    if (dut_q.size() != 1 || dut_q[0].t != 0 || dut_q[0].s != 3) begin
      n_fail++; $display("[TB] FAIL coalesce_count got %0d DLLPs want exactly one Ack seq 3", dut_q.size());
    end
  endtask

  task automatic test_ack_timeout();
    int first;
    dllp_ready_i = 1'b1;
    do_reset();
    cycle(1, 1, 0, 0);
    first = -1;
    for (int i = 1; i <= 100; i++) begin
      idle(1);
      if (first < 0 && dllp_valid_o === 1'b1) first = i;
      if (first >= 0 && i >= first + 2) break;
    end
    n_tests++;
    if (first != ACK_TIMEOUT) begin
      n_fail++; $display("[TB] FAIL ack_timeout_latency got=%0d cycles want=%0d", first, ACK_TIMEOUT);
    end
    n_tests++;
    if (dut_q.size() != 1 || dut_q[0].t != 0 || dut_q[0].s != 0) begin
      n_fail++; $display("[TB] FAIL ack_timeout_dllp got %0d DLLPs want one Ack seq 0", dut_q.size());
    end
  endtask

  task automatic test_nak();
    int naks[$];
    dllp_ready_i = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, i, 0);
    idle(2);
    cycle(1, 0, 7, 0);
    idle(1);
    cycle(1, 0, 9, 0);
    idle(3);
    cycle(1, 1, 5, 0);
    idle(1);
    cycle(1, 0, 3, 0);
    idle(3);
    foreach (dut_q[k]) if (dut_q[k].t == 1) naks.push_back(dut_q[k].s);
    n_tests++;
    if (naks.size() != 2) begin
      n_fail++; $display("[TB] FAIL nak_count got=%0d want=2", naks.size());
    end else begin
      n_tests++;
      if (naks[0] != 4 || naks[1] != 5) begin
        n_fail++; $display("[TB] FAIL nak_seqs got=%0d,%0d want=4,5", naks[0], naks[1]);
      end
    end
    n_tests++;
    if (next_rcv_seq_o !== 12'd6) begin
      n_fail++; $display("[TB] FAIL nak_next_seq got=%0d want=6", next_rcv_seq_o);
    end
    n_tests++;
    if (dut_q.size() != mdl_q.size()) begin
      n_fail++; $display("[TB] FAIL nak_stream_len got=%0d want=%0d", dut_q.size(), mdl_q.size());
    end else begin
      foreach (dut_q[k]) if (dut_q[k] != mdl_q[k]) begin
        n_fail++;
        $display("[TB] FAIL nak_stream[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", k,
                 dut_q[k].t, dut_q[k].s, dut_q[k].f, mdl_q[k].t, mdl_q[k].s, mdl_q[k].f);
        break;
      end
    end
  endtask

  task automatic test_duplicate();
    dllp_ready_i = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, i, 0);
    idle(2);
    cycle(1, 1, 2, 0);
    n_tests++;
    if (got_accept !== 1'b0) begin
      n_fail++; $display("[TB] FAIL dup_accept got=%b want=0", got_accept);
    end
    n_tests++;
    if (dllp_valid_o !== 1'b1 || dllp_type_o !== 2'd0 || dllp_seq_o !== 12'd4) begin
      n_fail++;
      $display("[TB] FAIL dup_ack got valid=%b type=%0d seq=%0d want 1/0/4", dllp_valid_o, dllp_type_o, dllp_seq_o);
    end
    n_tests++;
    if (next_rcv_seq_o !== 12'd5) begin
      n_fail++; $display("[TB] FAIL dup_next_seq got=%0d want=5", next_rcv_seq_o);
    end
    idle(2);
    cycle(1, 1, 9, 0);
    n_tests++;
    if (dllp_valid_o !== 1'b1 || dllp_type_o !== 2'd1 || dllp_seq_o !== 12'd4) begin
      n_fail++;
      $display("[TB] FAIL ooo_nak got valid=%b type=%0d seq=%0d want 1/1/4", dllp_valid_o, dllp_type_o, dllp_seq_o);
    end
    idle(2);
  endtask

  task automatic test_priority_hold();
    dllp_ready_i = 1'b0;
    fc_credit_i  = 12'h111;
    do_reset();
    cycle(1, 1, 0, 0);
    n_tests++;
    if (dllp_valid_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL hold_no_early_ack got valid=%b want 0", dllp_valid_o);
    end
    cycle(1, 0, 5, 1);
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (dllp_valid_o !== 1'b1 || dllp_type_o !== 2'd1 || dllp_seq_o !== 12'd0 || dllp_fc_o !== 12'd0) begin
        n_fail++;
        $display("[TB] FAIL hold_nak cyc=%0d got valid=%b type=%0d seq=%0d fc=%0d want 1/1/0/0",
                 i, dllp_valid_o, dllp_type_o, dllp_seq_o, dllp_fc_o);
      end
      idle(1);
    end
    dllp_ready_i = 1'b1;
    idle(1);
    n_tests++;
    if (dllp_valid_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL hold_gap got valid=%b want 0", dllp_valid_o);
    end
    dllp_ready_i = 1'b0;
    fc_credit_i  = 12'h2BC;
    idle(1);
    n_tests++;
    if (dllp_valid_o !== 1'b1 || dllp_type_o !== 2'd2 || dllp_fc_o !== 12'h2BC || dllp_seq_o !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL hold_fc got valid=%b type=%0d seq=%0d fc=%h want 1/2/0/2bc",
               dllp_valid_o, dllp_type_o, dllp_seq_o, dllp_fc_o);
    end
    dllp_ready_i = 1'b1;
    fc_credit_i  = 12'h333;
    idle(1);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      n_tests++;
      if (dllp_valid_o !== 1'b0) begin
        n_fail++; $display("[TB] FAIL hold_ack_discard cyc=%0d got valid=%b want 0", i, dllp_valid_o);
      end
    end
    n_tests++;
    if (dut_q.size() != 2 || dut_q[0].t != 1 || dut_q[0].s != 0 ||
        dut_q[1].t != 2 || dut_q[1].f != 'h2BC) begin
      n_fail++; $display("[TB] FAIL hold_stream got %0d DLLPs want Nak seq 0 then FC 2bc", dut_q.size());
    end
    dllp_ready_i = 1'b0;
    cycle(0, 0, 0, 1);
    idle(1);
    n_tests++;
    if (dllp_valid_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL hold_fc_req got valid=%b want 1", dllp_valid_o);
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_tests++;
    if (dllp_valid_o !== 1'b0 || dllp_type_o !== 2'd0 || dllp_fc_o !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL hold_reset got valid=%b type=%0d fc=%0d want 0/0/0", dllp_valid_o, dllp_type_o, dllp_fc_o);
    end
  endtask

  task automatic test_seq_wrap();
    int bad_acc;
    bit seen;
    dllp_ready_i = 1'b1;
    fc_credit_i  = 12'h040;
    do_reset();
    bad_acc = 0;
    for (int i = 0; i < 4096; i++) begin
      cycle(1, 1, i, 0);
      if (got_accept !== 1'b1) bad_acc++;
    end
    n_tests++;
    if (bad_acc != 0) begin
      n_fail++; $display("[TB] FAIL wrap_accept_all got %0d rejects want 0", bad_acc);
    end
    idle(4);
    n_tests++;
    if (next_rcv_seq_o !== 12'd0) begin
      n_fail++; $display("[TB] FAIL wrap_next_seq got=%0d want=0", next_rcv_seq_o);
    end
    cycle(1, 1, 4095, 0);
    n_tests++;
    if (got_accept !== 1'b0) begin
      n_fail++; $display("[TB] FAIL wrap_dup_accept got=%b want=0", got_accept);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (dllp_valid_o === 1'b1 && dllp_type_o === 2'd0) begin
        seen = 1;
        break;
      end
      idle(1);
    end
    n_tests++;
    if (!seen || dllp_seq_o !== 12'd4095) begin
      n_fail++; $display("[TB] FAIL wrap_dup_ack got seen=%0d seq=%0d want 1/4095", seen, dllp_seq_o);
    end
    idle(3);
    cycle(1, 1, 0, 0);
    n_tests++;
    if (got_accept !== 1'b1 || next_rcv_seq_o !== 12'd1) begin
      n_fail++; $display("[TB] FAIL wrap_seq0 got accept=%b next=%0d want 1/1", got_accept, next_rcv_seq_o);
    end
    idle(2);
    cycle(1, 1, 4095, 0);
    n_tests++;
    if (got_accept !== 1'b0 || next_rcv_seq_o !== 12'd1) begin
      n_fail++; $display("[TB] FAIL wrap_dup4095 got accept=%b next=%0d want 0/1", got_accept, next_rcv_seq_o);
    end
    idle(4);
    n_tests++;
    if (dut_q.size() != mdl_q.size()) begin
      n_fail++; $display("[TB] FAIL wrap_stream_len got=%0d want=%0d", dut_q.size(), mdl_q.size());
    end
  endtask

  task automatic test_fc_periodic();
    dllp_ready_i = 1'b1;
    fc_credit_i  = 12'h5A5;
    do_reset();
    idle(FC_PERIOD + 40);
    n_tests++;
    if (dut_q.size() != 1 || dut_q[0].t != 2 || dut_q[0].s != 0 || dut_q[0].f != 'h5A5) begin
      n_fail++; $display("[TB] FAIL fc_periodic got %0d DLLPs want one FC with credit 5a5", dut_q.size());
    end
    fc_credit_i = 12'h0C3;
    cycle(0, 0, 0, 1);
    n_tests++;
    if (dllp_valid_o !== 1'b1 || dllp_type_o !== 2'd2 || dllp_fc_o !== 12'h0C3) begin
      n_fail++;
      $display("[TB] FAIL fc_request got valid=%b type=%0d fc=%h want 1/2/0c3", dllp_valid_o, dllp_type_o, dllp_fc_o);
    end
    idle(2);
  endtask

  task automatic test_random();
    int r, seq, evt_pct, errs;
    dllp_ready_i = 1'b1;
    do_reset();
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      evt_pct = ((i / 500) % 2 == 0) ? 80 : 5;
      dllp_ready_i = ($urandom_range(0, 3) != 0);
      fc_credit_i  = 12'($urandom_range(0, 4095));
      rst = ($urandom_range(0, 599) == 0);
      r = $urandom_range(0, 99);
      if (r >= evt_pct) begin
        cycle(0, 0, 0, $urandom_range(0, 49) == 0);
      end else begin
        r = $urandom_range(0, 9);
        if (r < 6)       seq = m_nrs;
        else if (r == 6) seq = (m_nrs + 4095 - $urandom_range(0, 6)) % 4096;
        else             seq = (m_nrs + 1 + $urandom_range(0, 300)) % 4096;
        cycle(1, (r != 9), seq, $urandom_range(0, 49) == 0);
      end
      n_tests++;
      if (got_accept !== 1'(want_accept) || dllp_valid_o !== 1'(m_valid) ||
          dllp_type_o !== 2'(m_out.t) || dllp_seq_o !== 12'(m_out.s) ||
          dllp_fc_o !== 12'(m_out.f) || next_rcv_seq_o !== 12'(m_nrs)) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("[TB] FAIL random cyc=%0d got acc=%b v=%b t=%0d s=%0d f=%0d n=%0d want acc=%0d v=%0d t=%0d s=%0d f=%0d n=%0d",
                   i, got_accept, dllp_valid_o, dllp_type_o, dllp_seq_o, dllp_fc_o, next_rcv_seq_o,
                   want_accept, m_valid, m_out.t, m_out.s, m_out.f, m_nrs);
      end
    end
    rst = 1'b0;
    idle(2);
    n_tests++;
    if (dut_q.size() != mdl_q.size()) begin
      n_fail++; $display("[TB] FAIL random_stream_len got=%0d want=%0d", dut_q.size(), mdl_q.size());
    end else begin
      foreach (dut_q[k]) if (dut_q[k] != mdl_q[k]) begin
        n_fail++;
        $display("[TB] FAIL random_stream[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", k,
                 dut_q[k].t, dut_q[k].s, dut_q[k].f, mdl_q[k].t, mdl_q[k].s, mdl_q[k].f);
        break;
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    rx_evt_valid_i  = 1'b0;
    rx_evt_crc_ok_i = 1'b0;
    rx_evt_seq_i    = 12'd0;
    fc_credit_i     = 12'd0;
    fc_update_req_i = 1'b0;
    dllp_ready_i    = 1'b0;
    #2;
    test_reset();
    test_coalesce();
    test_ack_timeout();
    test_nak();
    test_duplicate();
    test_priority_hold();
    test_seq_wrap();
    test_fc_periodic();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
